exp_ctrl: RTL and testbench

- Trap sequencer that sits directly upstream of cs_registers.
- Watches the commit point (end of EX) for exceptions, external interrupts and MRET.
- Sequences the drain, flush, CSR save/restore and PC redirect. Drives cs_registers' save_exp / restore_exp / exp_code_i / mepc_i and consumes its mepc_o.
- Stalls the pipeline for the whole trap sequence.

---
 rtl/exp_ctrl_pkg.sv | 27 ++
 rtl/exp_ctrl_if.sv | 38 +++
 rtl/exp_ctrl_irq_sync.sv | 22 ++
 rtl/exp_ctrl.sv | 107 ++++++++++
 tb/tb_exp_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exp_ctrl_pkg.sv
// Shared types and constants for the exp_ctrl trap sequencer: FSM state
// encodings, event kinds, exception cause codes and the default trap vector.
package exp_ctrl_pkg;

  localparam int EXP_CODE_W = 6;
  typedef logic [EXP_CODE_W-1:0] exp_code_t;

  localparam exp_code_t EXP_ILLEGAL_INSN = 6'h02;
  localparam exp_code_t EXP_ECALL        = 6'h0B;
  localparam exp_code_t EXP_IRQ_EXT      = 6'h2B;

  localparam logic [31:0] EXP_MTVEC_DEFAULT = 32'h0000_0100;

  typedef enum logic [2:0] {
    EXP_ST_IDLE     = 3'd0,
    EXP_ST_DRAIN    = 3'd1,
    EXP_ST_SAVE     = 3'd2,
    EXP_ST_RESTORE  = 3'd3,
    EXP_ST_REDIRECT = 3'd4
  } exp_state_t;

  typedef enum logic {
    EXP_KIND_TRAP = 1'b0,
    EXP_KIND_RET  = 1'b1
  } exp_kind_t;

endpackage

// File: rtl/exp_ctrl_if.sv
// Bundle between exp_ctrl and its neighbours (commit stage, cs_registers, PC).
// The master modport is the trap sequencer itself; slave is the surrounding pipeline.
interface exp_ctrl_if;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_exp;
  logic [5:0]  ex_exp_code;
  logic        ex_mret;
  logic        irq;
  logic        mstatus_ie;
  logic        mem_busy;
  logic [31:0] mepc_rd;

  logic        save_exp;
  logic        restore_exp;
  logic [5:0]  exp_code_o;
  logic [31:0] epc_o;
  logic        flush_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_pc;

  modport master (
    input  ex_valid, ex_pc, ex_exp, ex_exp_code, ex_mret,
           irq, mstatus_ie, mem_busy, mepc_rd,
    output save_exp, restore_exp, exp_code_o, epc_o,
           flush_o, stall_o, redirect_o, redirect_pc
  );

  modport slave (
    output ex_valid, ex_pc, ex_exp, ex_exp_code, ex_mret,
           irq, mstatus_ie, mem_busy, mepc_rd,
    input  save_exp, restore_exp, exp_code_o, epc_o,
           flush_o, stall_o, redirect_o, redirect_pc
  );

endinterface

// File: rtl/exp_ctrl_irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt line.
// Used by exp_ctrl only when EXP_IRQ_SYNC_EN is defined.
module exp_ctrl_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exp_ctrl.sv
// Trap sequencer upstream of cs_registers: detects exceptions, interrupts and
// MRET at the commit point, then drains, flushes, saves/restores and redirects.
// Optional: define EXP_IRQ_SYNC_EN to pass irq through a two-flop synchronizer.
module exp_ctrl
  import exp_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_ADDR = EXP_MTVEC_DEFAULT,
  parameter exp_code_t   IRQ_CODE   = EXP_IRQ_EXT
) (
  input  logic       clk,
  input  logic       reset,
  exp_ctrl_if.master bus
);

  exp_state_t  state, state_next;
  exp_kind_t   kind_q, kind_next;
  exp_code_t   code_q, code_next;
  logic [31:0] epc_q, epc_next;
  logic [31:0] target_q, target_next;
  logic        irq_det;

`ifdef EXP_IRQ_SYNC_EN
  exp_ctrl_irq_sync u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.irq),
    .q     (irq_det)
  );
`else
  assign irq_det = bus.irq;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EXP_ST_IDLE;
      kind_q   <= EXP_KIND_TRAP;
      code_q   <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state    <= state_next;
      kind_q   <= kind_next;
      code_q   <= code_next;
      epc_q    <= epc_next;
      target_q <= target_next;
    end
  end

  // Event priority at the commit point: exception, then enabled interrupt, then MRET.
  always_comb begin
    state_next  = state;
    kind_next   = kind_q;
    code_next   = code_q;
    epc_next    = epc_q;
    target_next = target_q;
    unique case (state)
      EXP_ST_IDLE: begin
        if (bus.ex_valid) begin
          if (bus.ex_exp) begin
            kind_next  = EXP_KIND_TRAP;
            code_next  = bus.ex_exp_code;
            epc_next   = bus.ex_pc;
            state_next = bus.mem_busy ? EXP_ST_DRAIN : EXP_ST_SAVE;
          end else if (irq_det && bus.mstatus_ie) begin
            kind_next  = EXP_KIND_TRAP;
            code_next  = IRQ_CODE;
            epc_next   = bus.ex_pc;
            state_next = bus.mem_busy ? EXP_ST_DRAIN : EXP_ST_SAVE;
          end else if (bus.ex_mret) begin
            kind_next  = EXP_KIND_RET;
            state_next = bus.mem_busy ? EXP_ST_DRAIN : EXP_ST_RESTORE;
          end
        end
      end
      EXP_ST_DRAIN: begin
        if (!bus.mem_busy) begin
          state_next = (kind_q == EXP_KIND_TRAP) ? EXP_ST_SAVE : EXP_ST_RESTORE;
        end
      end
      EXP_ST_SAVE: begin
        target_next = MTVEC_ADDR;
        state_next  = EXP_ST_REDIRECT;
      end
      EXP_ST_RESTORE: begin
        target_next = bus.mepc_rd;
        state_next  = EXP_ST_REDIRECT;
      end
      EXP_ST_REDIRECT: begin
        state_next = EXP_ST_IDLE;
      end
      default: begin
        state_next = EXP_ST_IDLE;
      end
    endcase
  end

  // Outputs come only from state and latched registers, never straight from inputs.
  assign bus.save_exp    = (state == EXP_ST_SAVE);
  assign bus.restore_exp = (state == EXP_ST_RESTORE);
  assign bus.flush_o     = (state == EXP_ST_SAVE) || (state == EXP_ST_RESTORE);
  assign bus.redirect_o  = (state == EXP_ST_REDIRECT);
  assign bus.stall_o     = (state != EXP_ST_IDLE);
  assign bus.exp_code_o  = code_q;
  assign bus.epc_o       = epc_q;
  assign bus.redirect_pc = target_q;

endmodule

// File: tb/tb_exp_ctrl.sv
// Directed self-checking bench for exp_ctrl: reset, exception, drain, MRET,
// interrupt gating/priority/latency, reset mid-sequence and back-to-back events.
module tb_exp_ctrl;

`ifdef EXP_IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exp_ctrl_if bus ();

  exp_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ex_valid    = 1'b0;
    bus.ex_pc       = '0;
    bus.ex_exp      = 1'b0;
    bus.ex_exp_code = '0;
    bus.ex_mret     = 1'b0;
    bus.irq         = 1'b0;
    bus.mstatus_ie  = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.mepc_rd     = '0;
  endtask

  task automatic test_reset();
    logic [76:0] outs;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    outs = {bus.save_exp, bus.restore_exp, bus.exp_code_o, bus.epc_o,
            bus.flush_o, bus.stall_o, bus.redirect_o, bus.redirect_pc};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h want 0", outs);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_exception();
    bus.ex_valid = 1'b1; bus.ex_exp = 1'b1; bus.ex_exp_code = 6'h02; bus.ex_pc = 32'h40;
    tick();
    clear_inputs();
    checks++;
    if ({bus.save_exp, bus.restore_exp, bus.flush_o, bus.stall_o, bus.redirect_o} !== 5'b10110) begin
      failures++;
      $display("[TB] FAIL exc_t1_ctrl: got %b want 10110",
               {bus.save_exp, bus.restore_exp, bus.flush_o, bus.stall_o, bus.redirect_o});
    end
    checks++;
    if (bus.exp_code_o !== 6'h02 || bus.epc_o !== 32'h40) begin
      failures++;
      $display("[TB] FAIL exc_t1_code_epc: got %h/%h want 02/00000040", bus.exp_code_o, bus.epc_o);
    end
    tick();
    checks++;
    if ({bus.save_exp, bus.flush_o, bus.stall_o, bus.redirect_o} !== 4'b0011 || bus.redirect_pc !== 32'h100) begin
      failures++;
      $display("[TB] FAIL exc_t2_redirect: got ctrl=%b pc=%h want 0011 pc=00000100",
               {bus.save_exp, bus.flush_o, bus.stall_o, bus.redirect_o}, bus.redirect_pc);
    end
    tick();
    checks++;
    if (bus.stall_o !== 1'b0 || bus.redirect_o !== 1'b0 || bus.exp_code_o !== 6'h02) begin
      failures++;
      $display("[TB] FAIL exc_t3_release: got stall=%b redir=%b code=%h want 0 0 02",
               bus.stall_o, bus.redirect_o, bus.exp_code_o);
    end
  endtask

  task automatic test_drain();
    bus.ex_valid = 1'b1; bus.ex_exp = 1'b1; bus.ex_exp_code = 6'h0B; bus.ex_pc = 32'h48;
    bus.mem_busy = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.ex_valid = 1'b0; bus.ex_exp = 1'b0;
      if (c >= 3) bus.mem_busy = 1'b0;
      checks++;
      if (bus.stall_o !== (c <= 5) || bus.save_exp !== (c == 4) || bus.redirect_o !== (c == 5)) begin
        failures++;
        $display("[TB] FAIL drain_t%0d: got stall=%b save=%b redir=%b want %b %b %b", c,
                 bus.stall_o, bus.save_exp, bus.redirect_o, c <= 5, c == 4, c == 5);
      end
    end
    checks++;
    if (bus.exp_code_o !== 6'h0B || bus.epc_o !== 32'h48) begin
      failures++;
      $display("[TB] FAIL drain_code_epc: got %h/%h want 0b/00000048", bus.exp_code_o, bus.epc_o);
    end
  endtask

  task automatic test_mret();
    bus.ex_valid = 1'b1; bus.ex_mret = 1'b1; bus.mepc_rd = 32'h44;
    tick();
    bus.ex_valid = 1'b0; bus.ex_mret = 1'b0;
    checks++;
    if ({bus.save_exp, bus.restore_exp, bus.flush_o, bus.stall_o} !== 4'b0111) begin
      failures++;
      $display("[TB] FAIL mret_t1: got %b want 0111",
               {bus.save_exp, bus.restore_exp, bus.flush_o, bus.stall_o});
    end
    tick();
    bus.mepc_rd = 32'h0;
    checks++;
    if (bus.redirect_o !== 1'b1 || bus.redirect_pc !== 32'h44 || bus.restore_exp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mret_t2: got redir=%b pc=%h restore=%b want 1 00000044 0",
               bus.redirect_o, bus.redirect_pc, bus.restore_exp);
    end
    tick();
  endtask

  task automatic test_irq_gating();
    bus.irq = 1'b1; bus.mstatus_ie = 1'b0; bus.ex_valid = 1'b1; bus.ex_pc = 32'h60;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.stall_o !== 1'b0 || bus.save_exp !== 1'b0) begin
        failures++;
        $display("[TB] FAIL irq_masked_c%0d: got stall=%b save=%b want 0 0", c, bus.stall_o, bus.save_exp);
      end
    end
    bus.mstatus_ie = 1'b1; bus.ex_pc = 32'h80;
    tick();
    bus.ex_valid = 1'b0;
    checks++;
    if (bus.save_exp !== 1'b1 || bus.exp_code_o !== 6'h2B || bus.epc_o !== 32'h80) begin
      failures++;
      $display("[TB] FAIL irq_taken: got save=%b code=%h epc=%h want 1 2b 00000080",
               bus.save_exp, bus.exp_code_o, bus.epc_o);
    end
    tick();
    tick();
    bus.ex_valid = 1'b1; bus.ex_exp = 1'b1; bus.ex_exp_code = 6'h0B; bus.ex_pc = 32'h84;
    tick();
    clear_inputs();
    checks++;
    if (bus.save_exp !== 1'b1 || bus.exp_code_o !== 6'h0B || bus.epc_o !== 32'h84) begin
      failures++;
      $display("[TB] FAIL irq_vs_exc_priority: got save=%b code=%h epc=%h want 1 0b 00000084",
               bus.save_exp, bus.exp_code_o, bus.epc_o);
    end
    repeat (4) tick();
  endtask

  task automatic test_irq_latency();
    bus.ex_valid = 1'b1; bus.mstatus_ie = 1'b1; bus.ex_pc = 32'h90;
    tick();
    bus.irq = 1'b1;
    for (int c = 1; c <= IRQ_LAT + 1; c++) begin
      tick();
      checks++;
      if (bus.save_exp !== (c == IRQ_LAT + 1)) begin
        failures++;
        $display("[TB] FAIL irq_latency_t%0d: got save=%b want %b", c, bus.save_exp, c == IRQ_LAT + 1);
      end
    end
    clear_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_sequence();
    bit saw_save;
    logic [76:0] outs;
    saw_save = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_exp = 1'b1; bus.ex_exp_code = 6'h02; bus.ex_pc = 32'hA0;
    bus.mem_busy = 1'b1;
    tick();
    bus.ex_valid = 1'b0; bus.ex_exp = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_busy = 1'b0;
    outs = {bus.save_exp, bus.restore_exp, bus.exp_code_o, bus.epc_o,
            bus.flush_o, bus.stall_o, bus.redirect_o, bus.redirect_pc};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got %h want 0", outs);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.save_exp === 1'b1 || bus.stall_o === 1'b1) saw_save = 1'b1;
    end
    checks++;
    if (saw_save) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_save: got activity=1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    bus.ex_valid = 1'b1; bus.ex_exp = 1'b1; bus.ex_exp_code = 6'h02; bus.ex_pc = 32'h50;
    bus.mepc_rd = 32'h58;
    tick();
    bus.ex_exp = 1'b0; bus.ex_mret = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin
        checks++;
        if (bus.stall_o !== 1'b0 || bus.restore_exp !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_t3_idle: got stall=%b restore=%b want 0 0", bus.stall_o, bus.restore_exp);
        end
        tick();
        bus.ex_valid = 1'b0; bus.ex_mret = 1'b0;
      end else begin
        checks++;
        if (bus.restore_exp !== (c == 4) || (bus.save_exp & bus.restore_exp) !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_t%0d: got save=%b restore=%b want restore=%b", c,
                   bus.save_exp, bus.restore_exp, c == 4);
        end
        tick();
      end
    end
    checks++;
    if (bus.redirect_pc !== 32'h58) begin
      failures++;
      $display("[TB] FAIL b2b_redirect_pc: got %h want 00000058", bus.redirect_pc);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_exception();
    test_drain();
    test_mret();
    test_irq_gating();
    test_irq_latency();
    test_reset_mid_sequence();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
